serial_ugt_cmp: RTL

- Bit-serial unsigned magnitude comparator, the streaming counterpart of the parallel `coreir_ugt` primitive.
- Consumes two WIDTH-bit unsigned operands one bit pair per handshake, MSB first, and produces a registered ugt/ult/eq result word over a valid/ready output handshake.
- Sits behind a deserializing link where full-width operands are never assembled.

---
 rtl/serial_cmp_pkg.sv | 25 ++
 rtl/serial_cmp_decide.sv | 46 ++++
 rtl/serial_ugt_cmp.sv | 119 +++++++++++
 3 files changed

// File: rtl/serial_cmp_pkg.sv
// Shared definitions for the bit-serial comparator family.
package serial_cmp_pkg;

  // FSM state encoding.
  localparam int unsigned ST_W = 2;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_RESULT = 2'd2;

  // Result word presented on the output handshake.
  typedef struct packed {
    logic ugt;
    logic ult;
    logic eq;
  } cmp_result_t;

  // Bit counter width: clog2(max(width, 2)).
  function automatic int unsigned cnt_width(input int unsigned width);
    if (width < 2) begin
      return 1;
    end
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_cmp_decide.sv
// Decision cell: latches the first differing MSB-first bit pair as gt/lt.
module serial_cmp_decide (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic load,
  input  logic first,
  input  logic i0_bit,
  input  logic i1_bit,
  output logic gt_q,
  output logic lt_q,
  output logic gt_next_c,
  output logic lt_next_c
);

  logic gt_d;
  logic lt_d;

  // Fresh load on the first bit or while undecided; hold once decided.
  always_comb begin
    gt_d = gt_q;
    lt_d = lt_q;
    if (clear) begin
      gt_d = 1'b0;
      lt_d = 1'b0;
    end else if (load && (first || !(gt_q || lt_q))) begin
      gt_d = i0_bit & ~i1_bit;
      lt_d = ~i0_bit & i1_bit;
    end
  end

  assign gt_next_c = gt_d;
  assign lt_next_c = lt_d;

  // Decision registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      gt_q <= 1'b0;
      lt_q <= 1'b0;
    end else begin
      gt_q <= gt_d;
      lt_q <= lt_d;
    end
  end

endmodule

// File: rtl/serial_ugt_cmp.sv
// Bit-serial unsigned comparator: MSB-first bit pairs in, ugt/ult/eq word out.
module serial_ugt_cmp
  import serial_cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  input  logic in_valid,
  output logic in_ready,
  input  logic I0_bit,
  input  logic I1_bit,
  output logic out_valid,
  input  logic out_ready,
  output logic O_ugt,
  output logic O_ult,
  output logic O_eq
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [ST_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  cmp_result_t      res_q, res_d;

  logic accept_c;
  logic clear_c;
  logic gt_q, lt_q;
  logic gt_next_c, lt_next_c;

  assign in_ready = (state_q != ST_RESULT);
  assign accept_c = in_valid && in_ready;
  // A pending result must drain, so clear only acts while collecting bits.
  assign clear_c  = clear && (state_q != ST_RESULT);

  serial_cmp_decide u_decide (
    .clk       (CLK),
    .reset     (RESET),
    .clear     (clear_c),
    .load      (accept_c),
    .first     (cnt_q == '0),
    .i0_bit    (I0_bit),
    .i1_bit    (I1_bit),
    .gt_q      (gt_q),
    .lt_q      (lt_q),
    .gt_next_c (gt_next_c),
    .lt_next_c (lt_next_c)
  );

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    res_d       = '0;

    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (clear) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (accept_c) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_RESULT;
            cnt_d   = '0;
          end else begin
            state_d = ST_ACCUM;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_RESULT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Decision is frozen in RESULT, so the fields stay stable under backpressure.
    if (state_d == ST_RESULT) begin
      out_valid_d = 1'b1;
      res_d.ugt   = gt_next_c;
      res_d.ult   = lt_next_c;
      res_d.eq    = ~gt_next_c & ~lt_next_c;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
    end
  end

  assign out_valid = out_valid_q;
  assign O_ugt     = res_q.ugt;
  assign O_ult     = res_q.ult;
  assign O_eq      = res_q.eq;

  // Decision state is observed through res_q; direct copies kept for debug visibility.
  logic unused_dec_c;
  assign unused_dec_c = gt_q ^ lt_q;

endmodule
